// File: rtl/shift_pkg.sv
// Shared encodings and helpers for the multi-cycle shift sequencer.
package shift_pkg;

  localparam int unsigned SHAMT_W = 5;
  localparam int unsigned K_W     = SHAMT_W + 1;

  localparam logic [1:0] SH_SLL = 2'b00;
  localparam logic [1:0] SH_SRL = 2'b01;
  localparam logic [1:0] SH_SRA = 2'b10;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  // Bits to shift this cycle: min(remaining, step).
  function automatic logic [K_W-1:0] step_k(input logic [SHAMT_W-1:0] rem,
                                            input int unsigned step);
    if (K_W'(rem) < K_W'(step)) return K_W'(rem);
    else                        return K_W'(step);
  endfunction

endpackage

// File: rtl/shift_step.sv
// Bounded combinational shifter; SRA fill comes from the caller-supplied sign.
module shift_step
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  logic [DATA_W-1:0] value,
  input  logic [K_W-1:0]    k,
  input  logic [1:0]        op,
  input  logic              sign,
  output logic [DATA_W-1:0] shifted_c
);

  logic [DATA_W-1:0] fill;

  always_comb begin
    fill      = '0;
    shifted_c = value << k;
    if (sign) fill = ~({DATA_W{1'b1}} >> k);
    case (op)
      SH_SRL:  shifted_c = value >> k;
      SH_SRA:  shifted_c = (value >> k) | fill;
      default: shifted_c = value << k;
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// EX-stage shift sequencer: applies the shift STEP bits per cycle, returns
// the result over a valid/ready handshake and reports busy to hazard logic.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned STEP   = 8,
  parameter int unsigned TAG_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [1:0]        req_op,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [TAG_W-1:0]  req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy
);

  logic [1:0]         state, state_nxt;
  logic [DATA_W-1:0]  acc, acc_nxt;
  logic [SHAMT_W-1:0] rem, rem_nxt;
  logic [1:0]         op_q, op_nxt;
  logic               sign_q, sign_nxt;
  logic [TAG_W-1:0]   tag_q, tag_nxt;
  logic [K_W-1:0]     k_c;
  logic [DATA_W-1:0]  step_res;

  // Amount bits above the MIPS 5-bit field are architecturally ignored.
  logic unused_a_hi;
  assign unused_a_hi = ^req_a[DATA_W-1:SHAMT_W];

  assign req_ready = (state == S_IDLE) && !flush;
  assign busy      = (state != S_IDLE);
  assign rsp_valid = (state == S_DONE);
  assign rsp_data  = acc;
  assign rsp_tag   = tag_q;

  assign k_c = step_k(rem, STEP);

  shift_step #(.DATA_W(DATA_W)) u_step (
    .value     (acc),
    .k         (k_c),
    .op        (op_q),
    .sign      (sign_q),
    .shifted_c (step_res)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      acc    <= '0;
      rem    <= '0;
      op_q   <= SH_SLL;
      sign_q <= 1'b0;
      tag_q  <= '0;
    end else begin
      state  <= state_nxt;
      acc    <= acc_nxt;
      rem    <= rem_nxt;
      op_q   <= op_nxt;
      sign_q <= sign_nxt;
      tag_q  <= tag_nxt;
    end
  end

  // Next-state and datapath update; flush overrides every transition.
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    rem_nxt   = rem;
    op_nxt    = op_q;
    sign_nxt  = sign_q;
    tag_nxt   = tag_q;
    case (state)
      S_IDLE: begin
        if (req_valid && req_ready) begin
          acc_nxt   = req_b;
          rem_nxt   = req_a[SHAMT_W-1:0];
          op_nxt    = req_op;
          sign_nxt  = req_b[DATA_W-1];
          tag_nxt   = req_tag;
          state_nxt = (req_a[SHAMT_W-1:0] == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        acc_nxt = step_res;
        rem_nxt = rem - SHAMT_W'(k_c);
        if (rem_nxt == '0) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (flush) state_nxt = S_IDLE;
  end

endmodule

// File: doc/shift_seq_ctrl.md
Name: shift_seq_ctrl

Overview:
- Multi-cycle sequencer for the EX-stage shift unit; handles SLL, SRL and SRA.
- A request carries the value, shift amount, op and destination tag.
- The controller moves the value through a bounded per-cycle shifter of at most STEP bits until the full amount is applied, then returns the result with a valid/ready handshake.
- Drives a busy/stall indication back to the pipeline hazard logic.

Parameters:
- DATA_W, 32, operand/result width; fixed at 32 for this CPU.
- STEP, 8, maximum bits shifted per cycle; power of 2, 1..32.
- TAG_W, 5, destination-register tag width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous pipeline flush; abandons any in-flight operation.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 reserved (treated as SLL).
- req_a  in  32  shift amount source; only bits [4:0] are used.
- req_b  in  32  value to shift.
- req_tag  in  TAG_W  destination tag, returned unchanged with the result.
- rsp_valid  out  1  result present.
- rsp_ready  in  1  consumer accepts the result.
- rsp_data  out  32  shifted result.
- rsp_tag  out  TAG_W  tag of the result.
- busy  out  1  high whenever the state is not IDLE; used by hazard logic to stall.

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - rsp_valid=0, rsp_data=0, rsp_tag=0, busy=0, req_ready=1.
  - Internal accumulator, remaining count and op register are all cleared.
- States: IDLE, SHIFT, DONE.
- Port decode:
  - req_ready = (state==IDLE) && !flush.
  - busy = (state!=IDLE).
  - rsp_valid = (state==DONE).
- IDLE:
  - A request is accepted when req_valid && req_ready.
  - On accept, latch acc=req_b, rem=req_a[4:0], op and tag.
  - If req_a[4:0]==0, go to DONE; otherwise go to SHIFT.
- SHIFT, each cycle:
  - k = min(rem, STEP).
  - acc is shifted by k: logical left for SLL, logical right for SRL, arithmetic right for SRA, where SRA fills with the original bit 31 of the operand.
  - rem = rem - k.
  - When the new rem==0, go to DONE.
- DONE:
  - rsp_data=acc and rsp_tag are held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready, go to IDLE the next cycle; no new request is accepted in that same cycle.
- Latency: accept edge to rsp_valid = 1 + ceil(shamt/STEP) cycles.
  - STEP=8 values: shamt 0 → 1; shamt 1–8 → 2; shamt 31 → 5.
- Width rules:
  - The shift amount is taken modulo 32 (MIPS sllv/srlv/srav semantics); req_a bits [31:5] are ignored.
  - Bits shifted out are discarded. SLL/SRL fill with 0. SRA fills with the sign bit.
- Flush:
  - In any state, flush forces the state to IDLE next cycle and drops the result (rsp_valid=0 next cycle).
  - A request presented in the same cycle as flush is not accepted.
  - Flush takes priority over a rsp handshake in the same cycle; the consumer must ignore data in a flush cycle.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values; no partial result is ever presented.
- The result must equal a single-cycle barrel shift of req_b by req_a[4:0] for every op.

Decomposition:
- Shared package shift_pkg holds:
  - op encodings SH_SLL, SH_SRL, SH_SRA;
  - state enum constants S_IDLE, S_SHIFT, S_DONE;
  - SHAMT_W=5.
- One combinational sub-module, shift_step:
  - inputs: value, k (0..STEP), op, sign bit;
  - output: value shifted by k.
  - It is instantiated once; the controller holds all state.

Test Plan:
- Reset during SHIFT: rst_n low mid-operation → rsp_valid=0, busy=0, req_ready=1, rsp_data=0 immediately; a new request works normally after release.
- SLL, a=4, b=0x0000_00F1, rsp_ready=1 → rsp_valid 2 cycles after accept, rsp_data=0x0000_0F10, tag echoed.
- SRA, a=31, b=0x8000_0000, STEP=8 → 5-cycle latency, rsp_data=0xFFFF_FFFF; SRL with the same inputs → 0x0000_0001.
- Shift amount 0 and a=0x0000_0020 (modulo 32 gives 0), b=0x1234_5678 → 1-cycle latency, rsp_data=0x1234_5678 in both cases.
- Backpressure: rsp_ready=0 for 3 cycles in DONE → rsp_data and rsp_tag stable, req_ready=0, busy=1; a second req_valid is not accepted until the cycle after rsp_ready=1.
- Flush asserted in SHIFT → IDLE next cycle, no rsp_valid ever seen for that op; a request presented with flush is not accepted.
